// File: rtl/sum_stream_accumulator.sv
// Reduces one pass of LEN (index, sum) elements into a saturating total, an unsigned
// maximum and a sticky index-sequence error, presented on a valid/ready result port.
module sum_stream_accumulator #(
   parameter int unsigned LEN   = 256,
   parameter int unsigned ACC_W = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_index,
   input  logic [31:0]      in_sum,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_total,
   output logic [31:0]      res_max,
   output logic             res_sat,
   output logic             res_seq_err
);

   localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state_q;
   logic [ACC_W-1:0] total_q, total_d;
   logic [31:0]      max_q, max_d;
   logic             sat_q, sat_d;
   logic             seq_err_q, seq_err_d;
   logic [7:0]       exp_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q, res_valid_q, busy_q;
   logic [ACC_W:0]   sum_wide;
   logic             accept;

   // One spare bit catches the carry out of the accumulator; it forces all-ones and sat.
   always_comb begin
      accept    = in_valid && in_ready_q;
      sum_wide  = {1'b0, total_q} + {{(ACC_W - 31){1'b0}}, in_sum};
      total_d   = sum_wide[ACC_W-1:0];
      sat_d     = sat_q;
      if (sum_wide[ACC_W]) begin
         total_d = '1;
         sat_d   = 1'b1;
      end
      max_d     = (in_sum > max_q) ? in_sum : max_q;
      seq_err_d = seq_err_q | (in_index != exp_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         total_q     <= '0;
         max_q       <= '0;
         sat_q       <= 1'b0;
         seq_err_q   <= 1'b0;
         exp_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= ACCUM;
                  total_q    <= '0;
                  max_q      <= '0;
                  sat_q      <= 1'b0;
                  seq_err_q  <= 1'b0;
                  exp_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ACCUM: begin
               if (accept) begin
                  total_q   <= total_d;
                  max_q     <= max_d;
                  sat_q     <= sat_d;
                  seq_err_q <= seq_err_d;
                  exp_q     <= exp_q + 8'd1;
                  cnt_q     <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     state_q     <= DONE;
                     in_ready_q  <= 1'b0;
                     res_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_q     <= IDLE;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               res_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign res_valid   = res_valid_q;
   assign res_total   = total_q;
   assign res_max     = max_q;
   assign res_sat     = sat_q;
   assign res_seq_err = seq_err_q;

endmodule

// File: tb/tb_sum_stream_accumulator.sv
// Directed bench: three instances (LEN=4/ACC_W=40, LEN=4/ACC_W=32, LEN=256/ACC_W=40)
// share one input stream; each scenario task checks the instance it targets.
module tb_sum_stream_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_index = '0;
   logic [31:0] in_sum = '0;
   logic        res_ready = 1'b0;

   logic        a_in_ready, a_busy, a_res_valid, a_res_sat, a_res_seq_err;
   logic [39:0] a_res_total;
   logic [31:0] a_res_max;
   logic        b_in_ready, b_busy, b_res_valid, b_res_sat, b_res_seq_err;
   logic [31:0] b_res_total;
   logic [31:0] b_res_max;
   logic        c_in_ready, c_busy, c_res_valid, c_res_sat, c_res_seq_err;
   logic [39:0] c_res_total;
   logic [31:0] c_res_max;

   int errors = 0;
   int checks = 0;
   int c_accepts = 0;

   always #5 clk = ~clk;

   sum_stream_accumulator #(.LEN(4), .ACC_W(40)) u_a (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_index(in_index), .in_sum(in_sum), .busy(a_busy), .res_valid(a_res_valid),
      .res_ready(res_ready), .res_total(a_res_total), .res_max(a_res_max),
      .res_sat(a_res_sat), .res_seq_err(a_res_seq_err));

   sum_stream_accumulator #(.LEN(4), .ACC_W(32)) u_b (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_index(in_index), .in_sum(in_sum), .busy(b_busy), .res_valid(b_res_valid),
      .res_ready(res_ready), .res_total(b_res_total), .res_max(b_res_max),
      .res_sat(b_res_sat), .res_seq_err(b_res_seq_err));

   sum_stream_accumulator #(.LEN(256), .ACC_W(40)) u_c (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_index(in_index), .in_sum(in_sum), .busy(c_busy), .res_valid(c_res_valid),
      .res_ready(res_ready), .res_total(c_res_total), .res_max(c_res_max),
      .res_sat(c_res_sat), .res_seq_err(c_res_seq_err));

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic cyc();
      if (in_valid && c_in_ready) c_accepts++;
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [7:0] idx, input logic [31:0] sum);
      in_valid = 1'b1;
      in_index = idx;
      in_sum   = sum;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({a_in_ready, a_busy, a_res_valid, a_res_total, a_res_max, a_res_sat, a_res_seq_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b busy=%b vld=%b tot=%h max=%h sat=%b err=%b required all 0",
                  a_in_ready, a_busy, a_res_valid, a_res_total, a_res_max, a_res_sat, a_res_seq_err);
      end
   endtask

   task automatic test_basic_pass();
      res_ready = 1'b1;
      do_start();
      checks++;
      if ({a_in_ready, a_busy} !== 2'b11) begin
         errors++; $display("FAIL accum_entry: got rdy=%b busy=%b required 1 1", a_in_ready, a_busy);
      end
      feed(8'd0, 32'd10);
      feed(8'd1, 32'd20);
      feed(8'd2, 32'd30);
      feed(8'd3, 32'd40);
      checks++;
      if ({a_res_valid, a_in_ready, a_busy} !== 3'b101) begin
         errors++; $display("FAIL basic_done_flags: got vld=%b rdy=%b busy=%b required 1 0 1", a_res_valid, a_in_ready, a_busy);
      end
      checks++;
      if (a_res_total !== 40'd100 || a_res_max !== 32'd40 || a_res_sat !== 1'b0 || a_res_seq_err !== 1'b0) begin
         errors++; $display("FAIL basic_result: got tot=%0d max=%0d sat=%b err=%b required 100 40 0 0",
                            a_res_total, a_res_max, a_res_sat, a_res_seq_err);
      end
      cyc();
      checks++;
      if ({a_res_valid, a_busy} !== 2'b00 || a_res_total !== 40'd100) begin
         errors++; $display("FAIL basic_after_pulse: got vld=%b busy=%b tot=%0d required 0 0 100", a_res_valid, a_busy, a_res_total);
      end
   endtask

   task automatic test_gaps_and_stall();
      do_reset();
      res_ready = 1'b0;
      do_start();
      feed(8'd0, 32'd5);
      cyc();
      cyc();
      checks++;
      if (a_res_total !== 40'd5 || a_res_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         errors++; $display("FAIL gap_idle: got tot=%0d vld=%b rdy=%b required 5 0 1", a_res_total, a_res_valid, a_in_ready);
      end
      feed(8'd1, 32'd7);
      feed(8'd2, 32'd9);
      cyc();
      feed(8'd3, 32'd11);
      in_valid = 1'b1; in_index = 8'd0; in_sum = 32'd1000;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (a_res_valid !== 1'b1 || a_in_ready !== 1'b0 || a_res_total !== 40'd32 || a_res_max !== 32'd11 ||
             a_res_sat !== 1'b0 || a_res_seq_err !== 1'b0) begin
            errors++; $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b tot=%0d max=%0d sat=%b err=%b required 1 0 32 11 0 0",
                               i, a_res_valid, a_in_ready, a_res_total, a_res_max, a_res_sat, a_res_seq_err);
         end
         cyc();
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      checks++;
      if (a_res_valid !== 1'b1 || a_res_total !== 40'd32) begin
         errors++; $display("FAIL stall_final: got vld=%b tot=%0d required 1 32", a_res_valid, a_res_total);
      end
      cyc();
      checks++;
      if ({a_res_valid, a_busy} !== 2'b00) begin
         errors++; $display("FAIL stall_release: got vld=%b busy=%b required 0 0", a_res_valid, a_busy);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      res_ready = 1'b0;
      do_start();
      feed(8'd0, 32'hFFFF_FFF0);
      feed(8'd1, 32'h0000_0020);
      feed(8'd2, 32'h0000_0001);
      feed(8'd3, 32'h0000_0001);
      checks++;
      if (b_res_valid !== 1'b1 || b_res_total !== 32'hFFFF_FFFF || b_res_sat !== 1'b1 || b_res_max !== 32'hFFFF_FFF0) begin
         errors++; $display("FAIL saturate: got vld=%b tot=%h sat=%b max=%h required 1 ffffffff 1 fffffff0",
                            b_res_valid, b_res_total, b_res_sat, b_res_max);
      end
      checks++;
      if (a_res_total !== 40'h01_0000_0012 || a_res_sat !== 1'b0) begin
         errors++; $display("FAIL wide_no_saturate: got tot=%h sat=%b required 0100000012 0", a_res_total, a_res_sat);
      end
      res_ready = 1'b1;
      cyc();
   endtask

   task automatic test_seq_err();
      do_reset();
      res_ready = 1'b1;
      do_start();
      feed(8'd0, 32'd1);
      feed(8'd1, 32'd1);
      feed(8'd3, 32'd1);
      feed(8'd3, 32'd1);
      checks++;
      if (a_res_valid !== 1'b1 || a_res_seq_err !== 1'b1 || a_res_total !== 40'd4) begin
         errors++; $display("FAIL seq_err_set: got vld=%b err=%b tot=%0d required 1 1 4", a_res_valid, a_res_seq_err, a_res_total);
      end
      cyc();
      checks++;
      if (a_res_valid !== 1'b0 || a_res_seq_err !== 1'b1) begin
         errors++; $display("FAIL seq_err_hold_idle: got vld=%b err=%b required 0 1", a_res_valid, a_res_seq_err);
      end
      do_start();
      checks++;
      if (a_res_seq_err !== 1'b0 || a_res_total !== 40'd0 || a_res_max !== 32'd0) begin
         errors++; $display("FAIL start_clears: got err=%b tot=%0d max=%0d required 0 0 0", a_res_seq_err, a_res_total, a_res_max);
      end
      for (int i = 0; i < 4; i++) feed(8'(i), 32'd1);
      checks++;
      if (a_res_valid !== 1'b1 || a_res_seq_err !== 1'b0 || a_res_total !== 40'd4) begin
         errors++; $display("FAIL seq_ok_pass: got vld=%b err=%b tot=%0d required 1 0 4", a_res_valid, a_res_seq_err, a_res_total);
      end
      cyc();
   endtask

   task automatic test_midpass_reset();
      do_reset();
      res_ready = 1'b1;
      do_start();
      feed(8'd0, 32'd100);
      feed(8'd1, 32'd200);
      checks++;
      if (a_res_total !== 40'd300 || a_res_max !== 32'd200) begin
         errors++; $display("FAIL midpass_partial: got tot=%0d max=%0d required 300 200", a_res_total, a_res_max);
      end
      rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_index = 8'd2; in_sum = 32'd55;
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if ({a_in_ready, a_busy, a_res_valid, a_res_total, a_res_max, a_res_sat, a_res_seq_err} !== '0) begin
            errors++; $display("FAIL reset_override[%0d]: got rdy=%b busy=%b vld=%b tot=%0d max=%0d required all 0",
                               i, a_in_ready, a_busy, a_res_valid, a_res_total, a_res_max);
         end
      end
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      cyc();
      checks++;
      if ({a_in_ready, a_busy, a_res_valid, a_res_total} !== '0) begin
         errors++; $display("FAIL after_reset_idle: got rdy=%b busy=%b vld=%b tot=%0d required all 0",
                            a_in_ready, a_busy, a_res_valid, a_res_total);
      end
      do_start();
      for (int i = 0; i < 4; i++) feed(8'(i), 32'(i + 1));
      checks++;
      if (a_res_valid !== 1'b1 || a_res_total !== 40'd10 || a_res_max !== 32'd4) begin
         errors++; $display("FAIL post_reset_pass: got vld=%b tot=%0d max=%0d required 1 10 4", a_res_valid, a_res_total, a_res_max);
      end
      cyc();
   endtask

   task automatic test_full_len();
      do_reset();
      res_ready = 1'b0;
      c_accepts = 0;
      do_start();
      for (int i = 0; i < 256; i++) begin
         start = (i == 100 || i == 101);
         feed(8'(i), 32'hFFFF_FFFF);
      end
      start = 1'b0;
      checks++;
      if (c_res_valid !== 1'b1 || c_res_total !== 40'hFF_FFFF_FF00 || c_res_sat !== 1'b0 ||
          c_res_seq_err !== 1'b0 || c_res_max !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL full_len_result: got vld=%b tot=%h sat=%b err=%b max=%h required 1 ffffffff00 0 0 ffffffff",
                            c_res_valid, c_res_total, c_res_sat, c_res_seq_err, c_res_max);
      end
      start = 1'b1; in_valid = 1'b1; in_index = 8'd0; in_sum = 32'd7;
      for (int i = 0; i < 3; i++) cyc();
      start = 1'b0; in_valid = 1'b0;
      checks++;
      if (c_res_valid !== 1'b1 || c_in_ready !== 1'b0 || c_res_total !== 40'hFF_FFFF_FF00) begin
         errors++; $display("FAIL full_len_done_hold: got vld=%b rdy=%b tot=%h required 1 0 ffffffff00",
                            c_res_valid, c_in_ready, c_res_total);
      end
      checks++;
      if (c_accepts !== 256) begin
         errors++; $display("FAIL full_len_accepts: got %0d required 256", c_accepts);
      end
      res_ready = 1'b1;
      cyc();
      checks++;
      if ({c_res_valid, c_busy} !== 2'b00) begin
         errors++; $display("FAIL full_len_release: got vld=%b busy=%b required 0 0", c_res_valid, c_busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic_pass();
      test_gaps_and_stall();
      test_saturation();
      test_seq_err();
      test_midpass_reset();
      test_full_len();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
